// File: rtl/vga_stream_pkg.sv
// vga_stream_pkg: shared state type, pixel field layout, colour-bar table and
// raster boundary helpers for vga_stream_gen. The colour-bar helpers serve the
// optional TEST_PATTERN_EN build.
package vga_stream_pkg;

    localparam int CH_W      = 8;
    localparam int N_CH      = 3;
    localparam int PIX_W     = CH_W * N_CH;
    localparam int N_BARS    = 8;
    localparam int BAR_IDX_W = $clog2(N_BARS);

    localparam logic [CH_W-1:0] CH_ON  = '1;
    localparam logic [CH_W-1:0] CH_OFF = '0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    typedef struct packed {
        logic [CH_W-1:0] ch0;
        logic [CH_W-1:0] ch1;
        logic [CH_W-1:0] ch2;
    } pixel_t;

    // Total counts per axis: sync + back porch + active + front porch.
    function automatic int axis_total(input int sync_w, input int back_w,
                                      input int disp_w, input int front_w);
        return sync_w + back_w + disp_w + front_w;
    endfunction

    // First active position on an axis.
    function automatic int act_start(input int sync_w, input int back_w);
        return sync_w + back_w;
    endfunction

    // Counter width able to hold 0..total-1.
    function automatic int cnt_w(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    // Bar width in pixels; narrow displays still get 1-pixel bars.
    function automatic int bar_width(input int disp_w);
        return (disp_w >= N_BARS) ? disp_w / N_BARS : 1;
    endfunction

    // Bar number for an offset into the active line; the last bar absorbs
    // any remainder left by the integer division.
    function automatic logic [BAR_IDX_W-1:0] bar_index(input int offset, input int width);
        int idx;
        idx = offset / width;
        if (idx > N_BARS - 1) idx = N_BARS - 1;
        if (idx < 0)          idx = 0;
        return BAR_IDX_W'(idx);
    endfunction

    // Bars run white, yellow, cyan, green, magenta, red, blue, black:
    // ch0 is lit for bars 0,1,4,5, ch1 for bars 0..3, ch2 for even bars.
    function automatic pixel_t bar_colour(input logic [BAR_IDX_W-1:0] idx);
        pixel_t pix;
        pix.ch0 = idx[1] ? CH_OFF : CH_ON;
        pix.ch1 = idx[2] ? CH_OFF : CH_ON;
        pix.ch2 = idx[0] ? CH_OFF : CH_ON;
        return pix;
    endfunction

endpackage

// File: rtl/vga_timing_cnt.sv
// vga_timing_cnt: horizontal/vertical raster counters, region decode and the
// IDLE/RUN run-state. All region outputs are gated by RUN so IDLE looks like
// reset downstream. With TEST_PATTERN_EN the horizontal count is exported for
// the colour-bar generator.
module vga_timing_cnt
    import vga_stream_pkg::*;
#(
    parameter  int H_DISP  = 400,
    parameter  int V_DISP  = 306,
    parameter  int H_SYNC  = 2,
    parameter  int H_BACK  = 2,
    parameter  int H_FRONT = 2,
    parameter  int V_SYNC  = 1,
    parameter  int V_BACK  = 1,
    parameter  int V_FRONT = 1,
    localparam int H_TOTAL = axis_total(H_SYNC, H_BACK, H_DISP, H_FRONT),
    localparam int H_CW    = cnt_w(H_TOTAL)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
`ifdef TEST_PATTERN_EN
    output logic [H_CW-1:0] o_h_cnt,
`endif
    output logic            o_run,
    output logic            o_active,
    output logic            o_hsync_rgn,
    output logic            o_vsync_rgn,
    output logic            o_origin
);

    localparam int V_TOTAL = axis_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
    localparam int V_CW    = cnt_w(V_TOTAL);
    localparam int H_ACT0  = act_start(H_SYNC, H_BACK);
    localparam int H_ACT1  = H_ACT0 + H_DISP;
    localparam int V_ACT0  = act_start(V_SYNC, V_BACK);
    localparam int V_ACT1  = V_ACT0 + V_DISP;

    run_state_e      r_state;
    run_state_e      w_state_nxt;
    logic [H_CW-1:0] r_h_cnt;
    logic [V_CW-1:0] r_v_cnt;
    logic            w_h_last;
    logic            w_v_last;
    logic            w_frame_end;
    logic            w_h_act;
    logic            w_v_act;

    // Comparisons are done in int so an end bound equal to the total cannot
    // wrap inside a narrow counter width.
    assign w_h_last    = (int'(r_h_cnt) == H_TOTAL - 1);
    assign w_v_last    = (int'(r_v_cnt) == V_TOTAL - 1);
    assign w_frame_end = w_h_last && w_v_last;
    assign w_h_act     = (int'(r_h_cnt) >= H_ACT0) && (int'(r_h_cnt) < H_ACT1);
    assign w_v_act     = (int'(r_v_cnt) >= V_ACT0) && (int'(r_v_cnt) < V_ACT1);

    // Run-state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values whatever the statement order.
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Leave IDLE on en; return only at the end-of-frame wrap with en low.
    always_comb begin
        // NOTE: default assigned first so no path leaves w_state_nxt unassigned (no latch).
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (i_en)                    w_state_nxt = ST_RUN;
            ST_RUN:  if (w_frame_end && !i_en)    w_state_nxt = ST_IDLE;
            default:                              w_state_nxt = ST_IDLE;
        endcase
    end

    // Raster counters advance only in RUN; they are already 0 whenever IDLE is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + V_CW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + H_CW'(1);
            end
        end
    end

`ifdef TEST_PATTERN_EN
    assign o_h_cnt     = r_h_cnt;
`endif
    assign o_run       = (r_state == ST_RUN);
    assign o_active    = o_run && w_h_act && w_v_act;
    assign o_hsync_rgn = o_run && (int'(r_h_cnt) < H_SYNC);
    assign o_vsync_rgn = o_run && (int'(r_v_cnt) < V_SYNC);
    assign o_origin    = o_run && (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: rtl/vga_stream_gen.sv
// vga_stream_gen: VGA-style stream source. Timing comes from vga_timing_cnt;
// this level does the upstream valid/ready handshake, the registered stream
// outputs and the sticky underflow flag. Defining TEST_PATTERN_EN adds a
// test_mode input that replaces the upstream pixels with 8 colour bars.
module vga_stream_gen
    import vga_stream_pkg::*;
#(
    parameter int H_DISP   = 400,
    parameter int V_DISP   = 306,
    parameter int H_SYNC   = 2,
    parameter int H_BACK   = 2,
    parameter int H_FRONT  = 2,
    parameter int V_SYNC   = 1,
    parameter int V_BACK   = 1,
    parameter int V_FRONT  = 1,
    parameter int DATA_W   = PIX_W,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
`ifdef TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic              VGA_hsync,
    output logic              VGA_vsync,
    output logic              VGA_de,
    output logic [DATA_W-1:0] VGA_data,
    output logic              frame_start,
    output logic              underflow
);

    logic              w_active;
    logic              w_hsync_rgn;
    logic              w_vsync_rgn;
    logic              w_origin;
    logic              w_run;
    logic              w_pattern;
    logic              w_ready;
    logic              w_xfer;
    logic              w_underrun;
    logic [DATA_W-1:0] w_bar_data;
    logic [DATA_W-1:0] w_data_nxt;

    logic              r_hsync;
    logic              r_vsync;
    logic              r_de;
    logic [DATA_W-1:0] r_data;
    logic              r_frame_start;
    logic              r_underflow;

`ifdef TEST_PATTERN_EN
    localparam int H_TOTAL = axis_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
    localparam int H_CW    = cnt_w(H_TOTAL);
    localparam int H_ACT0  = act_start(H_SYNC, H_BACK);
    localparam int BAR_W   = bar_width(H_DISP);

    logic [H_CW-1:0]      w_h_cnt;
    logic [BAR_IDX_W-1:0] w_bar_idx;
    pixel_t               w_bar_pix;

    assign w_pattern  = test_mode;
    assign w_bar_idx  = bar_index(int'(w_h_cnt) - H_ACT0, BAR_W);
    assign w_bar_pix  = bar_colour(w_bar_idx);
    assign w_bar_data = DATA_W'(w_bar_pix);
`else
    assign w_pattern  = 1'b0;
    assign w_bar_data = '0;
`endif

    vga_timing_cnt #(
        .H_DISP  (H_DISP),
        .V_DISP  (V_DISP),
        .H_SYNC  (H_SYNC),
        .H_BACK  (H_BACK),
        .H_FRONT (H_FRONT),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_FRONT (V_FRONT)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .i_en        (en),
`ifdef TEST_PATTERN_EN
        .o_h_cnt     (w_h_cnt),
`endif
        .o_run       (w_run),
        .o_active    (w_active),
        .o_hsync_rgn (w_hsync_rgn),
        .o_vsync_rgn (w_vsync_rgn),
        .o_origin    (w_origin)
    );

    // Upstream is only asked for pixels during active video, never while the
    // bar pattern is on screen, so underflow cannot occur in pattern mode.
    assign w_ready    = w_active && !w_pattern;
    assign w_xfer     = w_ready && src_valid;
    assign w_underrun = w_ready && !src_valid;

    // Pixel selected for the next output cycle; blank unless something is shown.
    always_comb begin
        w_data_nxt = '0;
        if (w_active && w_pattern) w_data_nxt = w_bar_data;
        else if (w_xfer)           w_data_nxt = src_data;
    end

    // Stream outputs, registered one clock behind the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_de          <= 1'b0;
            r_data        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_hsync_rgn ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vsync_rgn ? SYNC_POL : ~SYNC_POL;
            r_de          <= w_active;
            r_data        <= w_data_nxt;
            r_frame_start <= w_origin;
        end
    end

    // Sticky underflow: cleared in step with frame_start (origin is never active).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_underflow <= 1'b0;
        else if (w_origin)   r_underflow <= 1'b0;
        else if (w_underrun) r_underflow <= 1'b1;
    end

    assign src_ready   = w_ready;
    assign VGA_hsync   = r_hsync;
    assign VGA_vsync   = r_vsync;
    assign VGA_de      = r_de;
    assign VGA_data    = r_data;
    assign frame_start = r_frame_start;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_vga_stream_gen.sv
// tb_vga_stream_gen: directed bench for vga_stream_gen on a 14x7 raster
// (8x4 active). A second instance with SYNC_POL=1 shares all inputs.
// Optional TEST_PATTERN_EN adds the colour-bar scenario.
`timescale 1ns/1ps
module tb_vga_stream_gen;

    localparam int DW    = 24;
    localparam int HT    = 14;
    localparam int VT    = 7;
    localparam int FRAME = 98;
    localparam int NOGAP = -10;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          src_valid;
    logic [DW-1:0] src_data;
`ifdef TEST_PATTERN_EN
    logic          test_mode;
`endif

    logic          src_ready, hs, vs, de, fs, uf;
    logic [DW-1:0] data;
    logic          p_ready, p_hs, p_vs, p_de, p_fs, p_uf;
    logic [DW-1:0] p_data;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int n_de;
        int first_de;
        int bad_de;
        int bad_data;
        int bad_hs;
        int bad_vs;
        int bad_hsp;
        int bad_vsp;
        int n_fs;
        int n_ready;
        int first_uf;
        int uf_drop;
    } stats_t;

    always #5 clk = ~clk;

    vga_stream_gen #(
        .H_DISP(8), .V_DISP(4), .H_SYNC(2), .H_BACK(2), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_FRONT(1), .DATA_W(DW), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
`ifdef TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .VGA_hsync(hs), .VGA_vsync(vs), .VGA_de(de), .VGA_data(data),
        .frame_start(fs), .underflow(uf)
    );

    vga_stream_gen #(
        .H_DISP(8), .V_DISP(4), .H_SYNC(2), .H_BACK(2), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_FRONT(1), .DATA_W(DW), .SYNC_POL(1'b1)
    ) dut_p (
        .clk(clk), .rst(rst), .en(en),
`ifdef TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .src_data(src_data), .src_valid(src_valid), .src_ready(p_ready),
        .VGA_hsync(p_hs), .VGA_vsync(p_vs), .VGA_de(p_de), .VGA_data(p_data),
        .frame_start(p_fs), .underflow(p_uf)
    );

    // Expected colour for bar i (hand-written table).
    function automatic logic [DW-1:0] bar_ref(input int i);
        case (i)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Advance to the next negedge; the upstream source moves to its next
    // pixel when a handshake happened on the edge in between.
    task automatic step();
        bit xfer;
        xfer = (src_ready === 1'b1) && (src_valid === 1'b1);
        @(negedge clk);
        if (xfer) src_data = src_data + 1'b1;
    endtask

    // Step until frame_start is seen or the budget runs out.
    task automatic wait_fs(input int limit, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (fs === 1'b1) break;
            step();
        end
        seen = (fs === 1'b1);
    endtask

    // Observe n_cyc output cycles starting at a frame_start cycle (c=0 is the
    // output of counter position 0). src_valid is low for stimulus cycles
    // gap_lo..gap_hi, which blanks outputs gap_lo+1..gap_hi+1.
    task automatic watch_frame(input int n_cyc, input int gap_lo, input int gap_hi,
                               input int drop_at, input bit pattern, output stats_t s);
        int            h, v, p, base;
        bit            ex_de, hole;
        logic [DW-1:0] ex_data;
        s = '{default: 0};
        s.first_de = -1;
        s.first_uf = -1;
        base = int'(src_data);
        p    = 0;
        for (int c = 0; c < n_cyc; c++) begin
            h     = c % HT;
            v     = (c / HT) % VT;
            ex_de = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
            hole  = (c >= gap_lo + 1) && (c <= gap_hi + 1);
            if (de !== ex_de) s.bad_de++;
            if (de === 1'b1) begin
                s.n_de++;
                if (s.first_de < 0) s.first_de = c;
            end
            if (hs   !== ((h < 2) ? 1'b0 : 1'b1)) s.bad_hs++;
            if (vs   !== ((v < 1) ? 1'b0 : 1'b1)) s.bad_vs++;
            if (p_hs !== ((h < 2) ? 1'b1 : 1'b0)) s.bad_hsp++;
            if (p_vs !== ((v < 1) ? 1'b1 : 1'b0)) s.bad_vsp++;
            if (c > 0 && fs === 1'b1) s.n_fs++;
            if (uf === 1'b1 && s.first_uf < 0) s.first_uf = c;
            if (uf !== 1'b1 && s.first_uf >= 0) s.uf_drop++;
            if (src_ready === 1'b1) s.n_ready++;
            if (pattern) begin
                ex_data = ex_de ? bar_ref(h - 4) : '0;
            end else if (ex_de && !hole) begin
                ex_data = DW'(base + p);
                p++;
            end else begin
                ex_data = '0;
            end
            if (data !== ex_data) s.bad_data++;
            src_valid = !((c >= gap_lo) && (c <= gap_hi));
            if (c == drop_at) en = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; src_valid = 1'b0; src_data = '0;
        repeat (3) @(negedge clk);
        n_total++; if (src_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", src_ready); else n_pass++;
        n_total++; if (hs !== 1'b1) $display("FAIL reset_hsync: got %b want 1", hs); else n_pass++;
        n_total++; if (vs !== 1'b1) $display("FAIL reset_vsync: got %b want 1", vs); else n_pass++;
        n_total++; if (de !== 1'b0) $display("FAIL reset_de: got %b want 0", de); else n_pass++;
        n_total++; if (data !== '0) $display("FAIL reset_data: got %h want 0", data); else n_pass++;
        n_total++; if (fs !== 1'b0) $display("FAIL reset_frame_start: got %b want 0", fs); else n_pass++;
        n_total++; if (uf !== 1'b0) $display("FAIL reset_underflow: got %b want 0", uf); else n_pass++;
        n_total++; if (p_hs !== 1'b0) $display("FAIL reset_hsync_pol1: got %b want 0", p_hs); else n_pass++;
        n_total++; if (p_vs !== 1'b0) $display("FAIL reset_vsync_pol1: got %b want 0", p_vs); else n_pass++;
    endtask

    task automatic test_stream();
        stats_t s;
        bit     seen;
        rst = 1'b0; en = 1'b1; src_valid = 1'b1; src_data = '0;
        wait_fs(10, seen);
        n_total++; if (seen !== 1'b1) $display("FAIL stream_start: frame_start seen %b want 1", seen); else n_pass++;
        watch_frame(FRAME, NOGAP, NOGAP, -1, 1'b0, s);
        n_total++; if (s.first_de != 32) $display("FAIL stream_first_de: got c=%0d want 32", s.first_de); else n_pass++;
        n_total++; if (s.n_de != 32) $display("FAIL stream_de_count: got %0d want 32", s.n_de); else n_pass++;
        n_total++; if (s.bad_de != 0) $display("FAIL stream_de_pos: %0d wrong cycles want 0", s.bad_de); else n_pass++;
        n_total++; if (s.bad_data != 0) $display("FAIL stream_data: %0d wrong pixels want 0", s.bad_data); else n_pass++;
        n_total++; if (s.bad_hs != 0) $display("FAIL stream_hsync: %0d wrong cycles want 0", s.bad_hs); else n_pass++;
        n_total++; if (s.bad_vs != 0) $display("FAIL stream_vsync: %0d wrong cycles want 0", s.bad_vs); else n_pass++;
        n_total++; if (s.n_ready != 32) $display("FAIL stream_ready_count: got %0d want 32", s.n_ready); else n_pass++;
        n_total++; if (s.n_fs != 0 || fs !== 1'b1) $display("FAIL stream_frame_period: extra=%0d next=%b want 0/1", s.n_fs, fs); else n_pass++;
        n_total++; if (s.first_uf != -1) $display("FAIL stream_underflow: rose at c=%0d want never", s.first_uf); else n_pass++;
    endtask

    task automatic test_sync_pol();
        stats_t s;
        watch_frame(FRAME, NOGAP, NOGAP, -1, 1'b0, s);
        n_total++; if (s.bad_hsp != 0) $display("FAIL pol1_hsync: %0d wrong cycles want 0", s.bad_hsp); else n_pass++;
        n_total++; if (s.bad_vsp != 0) $display("FAIL pol1_vsync: %0d wrong cycles want 0", s.bad_vsp); else n_pass++;
        n_total++; if (s.bad_data != 0) $display("FAIL pol_frame2_data: %0d wrong pixels want 0", s.bad_data); else n_pass++;
    endtask

    task automatic test_underflow();
        stats_t s;
        watch_frame(FRAME, 46, 48, -1, 1'b0, s);
        n_total++; if (s.first_uf != 47) $display("FAIL uf_rise: got c=%0d want 47", s.first_uf); else n_pass++;
        n_total++; if (s.uf_drop != 0) $display("FAIL uf_sticky: low %0d cycles after rise want 0", s.uf_drop); else n_pass++;
        n_total++; if (s.bad_data != 0) $display("FAIL uf_data: %0d wrong pixels want 0", s.bad_data); else n_pass++;
        n_total++; if (s.n_de != 32) $display("FAIL uf_de_count: got %0d want 32", s.n_de); else n_pass++;
        n_total++; if (fs !== 1'b1) $display("FAIL uf_next_frame: frame_start %b want 1", fs); else n_pass++;
        n_total++; if (uf !== 1'b0) $display("FAIL uf_clear: got %b want 0", uf); else n_pass++;
    endtask

    task automatic test_en_drop();
        stats_t s;
        int     bad_idle;
        watch_frame(FRAME, NOGAP, NOGAP, 41, 1'b0, s);
        n_total++; if (s.n_de != 32) $display("FAIL drop_de_count: got %0d want 32", s.n_de); else n_pass++;
        n_total++; if (s.bad_data != 0) $display("FAIL drop_data: %0d wrong pixels want 0", s.bad_data); else n_pass++;
        n_total++; if (s.bad_hs != 0) $display("FAIL drop_hsync: %0d wrong cycles want 0", s.bad_hs); else n_pass++;
        n_total++; if (fs !== 1'b0) $display("FAIL drop_no_restart: frame_start %b want 0", fs); else n_pass++;
        bad_idle = 0;
        for (int k = 0; k < 100; k++) begin
            if (de !== 1'b0 || fs !== 1'b0 || src_ready !== 1'b0 || hs !== 1'b1 || vs !== 1'b1 || p_hs !== 1'b0)
                bad_idle++;
            step();
        end
        n_total++; if (bad_idle != 0) $display("FAIL drop_idle: %0d non-idle cycles want 0", bad_idle); else n_pass++;
    endtask

    task automatic test_reset_mid();
        stats_t s;
        bit     seen;
        en = 1'b1; src_valid = 1'b1;
        wait_fs(10, seen);
        n_total++; if (seen !== 1'b1) $display("FAIL mid_start: frame_start seen %b want 1", seen); else n_pass++;
        watch_frame(47, 35, 35, -1, 1'b0, s);
        n_total++; if (uf !== 1'b1 || de !== 1'b1) $display("FAIL mid_pre_state: uf=%b de=%b want 1/1", uf, de); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (de !== 1'b0) $display("FAIL mid_async_de: got %b want 0", de); else n_pass++;
        n_total++; if (data !== '0) $display("FAIL mid_async_data: got %h want 0", data); else n_pass++;
        n_total++; if (uf !== 1'b0) $display("FAIL mid_async_underflow: got %b want 0", uf); else n_pass++;
        n_total++; if (src_ready !== 1'b0) $display("FAIL mid_async_ready: got %b want 0", src_ready); else n_pass++;
        n_total++; if (hs !== 1'b1 || vs !== 1'b1) $display("FAIL mid_async_sync: hs=%b vs=%b want 1/1", hs, vs); else n_pass++;
        src_data = '0;
        @(negedge clk);
        rst = 1'b0;
        wait_fs(3, seen);
        n_total++; if (seen !== 1'b1) $display("FAIL mid_restart: frame_start seen %b want 1", seen); else n_pass++;
        watch_frame(FRAME, NOGAP, NOGAP, -1, 1'b0, s);
        n_total++; if (s.first_de != 32) $display("FAIL mid_first_de: got c=%0d want 32", s.first_de); else n_pass++;
        n_total++; if (s.bad_data != 0) $display("FAIL mid_data_restart: %0d wrong pixels want 0", s.bad_data); else n_pass++;
        n_total++; if (s.n_de != 32) $display("FAIL mid_de_count: got %0d want 32", s.n_de); else n_pass++;
    endtask

`ifdef TEST_PATTERN_EN
    task automatic test_pattern();
        stats_t s;
        test_mode = 1'b1;
        watch_frame(FRAME, NOGAP, NOGAP, -1, 1'b1, s);
        test_mode = 1'b0;
        n_total++; if (s.bad_data != 0) $display("FAIL pattern_bars: %0d wrong pixels want 0", s.bad_data); else n_pass++;
        n_total++; if (s.n_ready != 0) $display("FAIL pattern_ready: high %0d cycles want 0", s.n_ready); else n_pass++;
        n_total++; if (s.first_uf != -1) $display("FAIL pattern_underflow: rose at c=%0d want never", s.first_uf); else n_pass++;
        n_total++; if (s.n_de != 32) $display("FAIL pattern_de_count: got %0d want 32", s.n_de); else n_pass++;
    endtask
`endif

    initial begin
`ifdef TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        test_reset();
        test_stream();
        test_sync_pol();
        test_underflow();
        test_en_drop();
        test_reset_mid();
`ifdef TEST_PATTERN_EN
        test_pattern();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
